// File: rtl/render_job_scheduler.sv
// Frame job scheduler: walks every pixel of a WIDTH x HEIGHT frame, deals jobs round-robin to the
// renderer cores and funnels their results through a round-robin arbiter onto one framebuffer port.
module render_job_scheduler #(
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 180,
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  output logic                          busy_out,
  output logic                          done_out,
  output logic [NUM_CORES-1:0]          job_valid_out,
  input  logic [NUM_CORES-1:0]          job_ready_in,
  output logic [8:0]                    job_x_out,
  output logic [7:0]                    job_y_out,
  output logic [ADDR_W-1:0]             job_addr_out,
  input  logic [NUM_CORES-1:0]          res_valid_in,
  output logic [NUM_CORES-1:0]          res_ready_out,
  input  logic [NUM_CORES*ADDR_W-1:0]   res_addr_in,
  input  logic [NUM_CORES*8-1:0]        res_color_in,
  output logic                          fb_we_out,
  output logic [ADDR_W-1:0]             fb_addr_out,
  output logic [7:0]                    fb_data_out,
  output logic [1:0]                    state_dbg
);

  // Valid/ready: a transfer happens on a rising clk_in edge where both valid and ready are high;
  // an offer, once raised, keeps its target core and payload unchanged until that transfer.

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TOTAL     = CNT_W'(WIDTH * HEIGHT);
  localparam logic [CNT_W-1:0] TOTAL_M1  = CNT_W'(WIDTH * HEIGHT - 1);
  localparam logic [PTR_W-1:0] LAST_CORE = PTR_W'(NUM_CORES - 1);
  localparam logic [8:0]       LAST_X    = 9'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [8:0]        x_q;
  logic [7:0]        y_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  issued_q, retired_q;
  logic [PTR_W-1:0]  dptr_q, rptr_q;

  logic              active, job_fire, last_job, frame_retired;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx, cand;
  logic [NUM_CORES-1:0] grant;

  assign active        = (state == S_DISPATCH) || (state == S_DRAIN);
  assign job_fire      = (state == S_DISPATCH) && job_ready_in[dptr_q];
  assign last_job      = (issued_q == TOTAL_M1);
  // The final grant moves straight to DONE so done_out lines up with the last framebuffer write.
  assign frame_retired = (retired_q == TOTAL) || (grant_any && (retired_q == TOTAL_M1));

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (active) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        cand = PTR_W'((int'(rptr_q) + k) % NUM_CORES);
        if (!grant_any && res_valid_in[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start_in) state_nxt = S_DISPATCH;
      S_DISPATCH: if (job_fire && last_job) state_nxt = S_DRAIN;
      S_DRAIN:    if (frame_retired) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    job_valid_out = '0;
    if (state == S_DISPATCH) job_valid_out[dptr_q] = 1'b1;
  end

  assign busy_out      = active;
  assign done_out      = (state == S_DONE);
  assign res_ready_out = grant;
  assign job_x_out     = x_q;
  assign job_y_out     = y_q;
  assign job_addr_out  = addr_q;
  assign state_dbg     = state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      issued_q    <= '0;
      retired_q   <= '0;
      dptr_q      <= '0;
      rptr_q      <= '0;
      fb_we_out   <= 1'b0;
      fb_addr_out <= '0;
      fb_data_out <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start_in) begin
        x_q       <= '0;
        y_q       <= '0;
        addr_q    <= '0;
        issued_q  <= '0;
        retired_q <= '0;
        dptr_q    <= '0;
        rptr_q    <= '0;
      end else begin
        if (job_fire) begin
          issued_q <= issued_q + 1'b1;
          addr_q   <= addr_q + 1'b1;
          dptr_q   <= (dptr_q == LAST_CORE) ? '0 : dptr_q + 1'b1;
          if (x_q == LAST_X) begin
            x_q <= '0;
            y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
        if (grant_any) begin
          retired_q <= retired_q + 1'b1;
          rptr_q    <= (grant_idx == LAST_CORE) ? '0 : grant_idx + 1'b1;
        end
      end
      fb_we_out <= grant_any;
      if (grant_any) begin
        fb_addr_out <= res_addr_in[int'(grant_idx)*ADDR_W +: ADDR_W];
        fb_data_out <= res_color_in[int'(grant_idx)*8 +: 8];
      end
    end
  end

endmodule
